// File: rtl/crc8_pkg.sv
// Shared CRC-8 constants and framer state encoding, used by both the
// transmit framer and the receive-side checker.
package crc8_pkg;

   localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
   localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

   typedef enum logic {
      ST_DATA = 1'b0,
      ST_CRC  = 1'b1
   } crc8_state_e;

endpackage

// File: rtl/crc8_byte_next.sv
// One-byte CRC-8 update, MSB-first, no reflection; bit-exact with the
// parallel 8-bit CRC engine.
module crc8_byte_next #(
   parameter logic [7:0] POLY = 8'h07
) (
   input  logic [7:0] crc_in,
   input  logic [7:0] data,
   output logic [7:0] crc_out
);

   logic [7:0] c;

   always_comb begin
      c = crc_in ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/crc8_frame_append.sv
// Forwards payload bytes through a registered output slot and appends the
// running CRC-8 as one extra byte after each frame's last payload byte.
module crc8_frame_append
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLY  = CRC8_POLY_DEFAULT,
   parameter logic [7:0] INIT  = CRC8_INIT_DEFAULT,
   parameter int         CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   output logic [7:0]       m_data,
   output logic             m_valid,
   output logic             m_last,
   input  logic             m_ready,
   output logic [CNT_W-1:0] frame_cnt
);

   crc8_state_e      state_q, state_d;
   logic [7:0]       crc_q, crc_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [7:0]       m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d;
   logic             m_last_q, m_last_d;
   logic [7:0]       crc_upd;
   logic             slot_free;
   logic             accept;

   crc8_byte_next #(.POLY(POLY)) u_crc_next (
      .crc_in (crc_q),
      .data   (s_data),
      .crc_out(crc_upd)
   );

   // The slot can take a new byte whenever it is empty or draining this cycle.
   assign slot_free = !m_valid_q || m_ready;
   assign s_ready   = (state_q == ST_DATA) && slot_free;
   assign accept    = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_DATA;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_DATA: if (accept && s_last) state_d = ST_CRC;
         ST_CRC:  if (slot_free)        state_d = ST_DATA;
         default: state_d = ST_DATA;
      endcase
   end

   always_comb begin
      crc_d       = crc_q;
      frame_cnt_d = frame_cnt_q;
      m_data_d    = m_data_q;
      m_last_d    = m_last_q;
      m_valid_d   = m_valid_q && !m_ready;
      case (state_q)
         ST_DATA: begin
            if (accept) begin
               m_data_d  = s_data;
               m_valid_d = 1'b1;
               m_last_d  = 1'b0;
               crc_d     = crc_upd;
            end
         end
         ST_CRC: begin
            if (slot_free) begin
               m_data_d    = crc_q;
               m_valid_d   = 1'b1;
               m_last_d    = 1'b1;
               crc_d       = INIT;
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q       <= INIT;
         frame_cnt_q <= '0;
         m_data_q    <= 8'h00;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
      end else begin
         crc_q       <= crc_d;
         frame_cnt_q <= frame_cnt_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
      end
   end

   assign m_data    = m_data_q;
   assign m_valid   = m_valid_q;
   assign m_last    = m_last_q;
   assign frame_cnt = frame_cnt_q;

endmodule
